// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared constants and configuration helpers for the pipelined ripple adder.
// Holds no typedefs; the datapath is sized entirely by module parameters.
package pipelined_ripple_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 16;
  localparam int unsigned DEFAULT_STAGES = 4;

  // Bits handled by one pipeline stage.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  // A configuration is usable when every stage owns at least one whole bit.
  function automatic bit legal_config(input int unsigned width,
                                      input int unsigned stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_ripple_adder_chunk.sv
// Combinational C-bit ripple-carry adder built from per-bit full adders.
// Also reports the carry into its MSB so the last chunk can derive signed overflow.
module ripple_chunk_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int unsigned C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic [C-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [C:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < C; i++) begin : g_fa
    logic half;
    assign half       = a[i] ^ b[i];
    assign sum[i]     = half ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & half);
  end

  assign cout = carry[C];
  assign cmsb = carry[C-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Valid/ready add/subtract unit: one C-bit chunk per stage, carry registered between
// stages, upper operand chunks skewed forward and finished sum chunks shifted in on top.
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned C = chunk_width(WIDTH, STAGES);

  if (!legal_config(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_ripple_adder: WIDTH must be a nonzero multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  // Pipeline registers: skewed operands (already shifted so the next chunk sits at
  // bit 0), partial sums (finished chunks accumulate from the top down), carries.
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_sk [STAGES];
  logic [WIDTH-1:0]  b_sk [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic              ovf_q;

  logic [C-1:0]      op_a   [STAGES];
  logic [C-1:0]      op_b   [STAGES];
  logic [C-1:0]      ch_sum [STAGES];
  logic [STAGES-1:0] op_cin;
  logic [STAGES-1:0] ch_cout;
  logic [STAGES-1:0] ch_cmsb;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Subtract is a + ~b + 1, so carry_in is overridden in that mode.
  assign b_eff = sub ? ~b : b;
  assign cin0  = sub ? 1'b1 : carry_in;

  assign op_a[0]   = a[C-1:0];
  assign op_b[0]   = b_eff[C-1:0];
  assign op_cin[0] = cin0;

  for (genvar k = 1; k < STAGES; k++) begin : g_operands
    assign op_a[k]   = a_sk[k-1][C-1:0];
    assign op_b[k]   = b_sk[k-1][C-1:0];
    assign op_cin[k] = c_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    ripple_chunk_adder #(.C(C)) u_chunk (
      .a    (op_a[k]),
      .b    (op_b[k]),
      .cin  (op_cin[k]),
      .sum  (ch_sum[k]),
      .cout (ch_cout[k]),
      .cmsb (ch_cmsb[k])
    );
  end

  // Stage registers: reset clears every slot so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_sk[k] <= '0;
        b_sk[k] <= '0;
        s_q[k]  <= '0;
      end
    end else if (adv) begin
      vld     <= (vld << 1) | STAGES'(in_valid);
      c_q     <= ch_cout;
      ovf_q   <= ch_cout[STAGES-1] ^ ch_cmsb[STAGES-1];
      a_sk[0] <= a >> C;
      b_sk[0] <= b_eff >> C;
      s_q[0]  <= WIDTH'(ch_sum[0]) << (WIDTH - C);
      for (int unsigned k = 1; k < STAGES; k++) begin
        a_sk[k] <= a_sk[k-1] >> C;
        b_sk[k] <= b_sk[k-1] >> C;
        s_q[k]  <= (s_q[k-1] >> C) | (WIDTH'(ch_sum[k]) << (WIDTH - C));
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow  = ovf_q;

  // Last-stage skew and the lower chunks' MSB carries carry no information.
  logic unused_sink;
  assign unused_sink = ^{a_sk[STAGES-1], b_sk[STAGES-1], ch_cmsb};

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed and randomised checks of pipelined_ripple_adder at WIDTH=16, STAGES=4.
module tb_pipelined_ripple_adder;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // Hand-computed stream vectors: {a, b, cin, sub, sum, carry_out, overflow}.
  function automatic vec_t get_vec(input int i);
    vec_t v;
    case (i)
      0:       v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
      1:       v = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      2:       v = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      3:       v = '{16'hFFFF, 16'h0002, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
      4:       v = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      5:       v = '{16'h0003, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
      6:       v = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      default: v = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    endcase
    return v;
  endfunction

  // Reference: plain 17-bit arithmetic, overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [16:0] r;
    logic [15:0] ny;
    logic        ov;
    ny = ~y;
    if (s) begin
      r  = {1'b0, x} + {1'b0, ny} + 17'd1;
      ov = (x[15] != y[15]) && (r[15] != x[15]);
    end else begin
      r  = {1'b0, x} + {1'b0, y} + 17'(ci);
      ov = (x[15] == y[15]) && (r[15] != x[15]);
    end
    return {r[15:0], r[16], ov};
  endfunction

  task automatic drive_op(input vec_t v);
    a        = v.a;
    b        = v.b;
    carry_in = v.cin;
    sub      = v.sub;
    in_valid = 1'b1;
  endtask

  // Issues one op into an empty pipe and reports the cycle its result appears (-1 = never).
  task automatic run_op(input vec_t v, output logic [15:0] s, output logic co,
                        output logic ov, output int lat);
    out_ready = 1'b1;
    drive_op(v);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    s = 'x; co = 1'bx; ov = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid === 1'b1) begin
        lat = i;
        s = sum; co = carry_out; ov = overflow;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    vec_t v;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
    n_tests++;
    if (sum !== 16'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: sum=%h co=%b ov=%b, expected 0000/0/0", sum, carry_out, overflow);
    end
    // Park a result at the output, then reset must clear it.
    v = '{16'h00AA, 16'h0055, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0};
    out_ready = 1'b0;
    drive_op(v);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || sum !== 16'h00FF) begin
      n_fail++;
      $display("FAIL parked_result: out_valid=%b sum=%h, expected 1/00ff", out_valid, sum);
    end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 16'h00FF) begin
      n_fail++;
      $display("FAIL parked_hold: in_ready=%b out_valid=%b sum=%h, expected 0/1/00ff",
               in_ready, out_valid, sum);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || carry_out !== 1'b0 || overflow !== 1'b0
        || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_clears: out_valid=%b sum=%h co=%b ov=%b in_ready=%b, expected 0/0000/0/0/1",
               out_valid, sum, carry_out, overflow, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic [15:0] s; logic co, ov; int lat;
    run_op('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0}, s, co, ov, lat);
    n_tests++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL latency: result after %0d cycles, expected 4", lat);
    end
    n_tests++;
    if ({s, co, ov} !== {16'h0100, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_00ff_1: got %h/%b/%b, expected 0100/0/0", s, co, ov);
    end
  endtask

  task automatic test_carry_chain();
    vec_t tbl [4];
    logic [15:0] s; logic co, ov; int lat;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i], s, co, ov, lat);
      n_tests++;
      if (lat != 4 || {s, co, ov} !== {tbl[i].s, tbl[i].co, tbl[i].ov}) begin
        n_fail++;
        $display("FAIL carry[%0d]: got %h/%b/%b lat %0d, expected %h/%b/%b lat 4",
                 i, s, co, ov, lat, tbl[i].s, tbl[i].co, tbl[i].ov);
      end
    end
  endtask

  task automatic test_subtract();
    vec_t tbl [3];
    logic [15:0] s; logic co, ov; int lat;
    tbl[0] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[2] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(tbl[i], s, co, ov, lat);
      n_tests++;
      if (lat != 4 || {s, co, ov} !== {tbl[i].s, tbl[i].co, tbl[i].ov}) begin
        n_fail++;
        $display("FAIL sub[%0d]: got %h/%b/%b lat %0d, expected %h/%b/%b lat 4",
                 i, s, co, ov, lat, tbl[i].s, tbl[i].co, tbl[i].ov);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v;
    int n_in, n_out, last_c, stall_left;
    bit stalling, dup;
    // Unstalled stream: 8 results on consecutive cycles.
    n_in = 0; n_out = 0; last_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && n_out < 8; c++) begin
      if (n_in < 8) drive_op(get_vec(n_in));
      else in_valid = 1'b0;
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        v = get_vec(n_out);
        n_tests++;
        if ({sum, carry_out, overflow} !== {v.s, v.co, v.ov}) begin
          n_fail++;
          $display("FAIL stream[%0d]: got %h/%b/%b, expected %h/%b/%b",
                   n_out, sum, carry_out, overflow, v.s, v.co, v.ov);
        end
        if (n_out > 0) begin
          n_tests++;
          if (c != last_c + 1) begin
            n_fail++;
            $display("FAIL stream_gap[%0d]: cycle %0d, expected %0d", n_out, c, last_c + 1);
          end
        end
        last_c = c;
        n_out++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) n_in++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++;
    if (n_out != 8) begin
      n_fail++;
      $display("FAIL stream_count: %0d results, expected 8", n_out);
    end

    // Same stream with a 5-cycle consumer stall after two results.
    n_in = 0; n_out = 0; stall_left = 5;
    for (int c = 0; c < 80 && n_out < 8; c++) begin
      stalling = (n_out == 2) && (stall_left > 0);
      out_ready = !stalling;
      if (n_in < 8) drive_op(get_vec(n_in));
      else in_valid = 1'b0;
      #1;
      if (stalling) begin
        v = get_vec(2);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1
            || {sum, carry_out, overflow} !== {v.s, v.co, v.ov}) begin
          n_fail++;
          $display("FAIL stall_hold[%0d]: in_ready=%b out_valid=%b out=%h/%b/%b, expected 0/1/%h/%b/%b",
                   5 - stall_left, in_ready, out_valid, sum, carry_out, overflow, v.s, v.co, v.ov);
        end
        stall_left--;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        v = get_vec(n_out);
        n_tests++;
        if ({sum, carry_out, overflow} !== {v.s, v.co, v.ov}) begin
          n_fail++;
          $display("FAIL drain[%0d]: got %h/%b/%b, expected %h/%b/%b",
                   n_out, sum, carry_out, overflow, v.s, v.co, v.ov);
        end
        n_out++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) n_in++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    if (n_out != 8 || stall_left != 0) begin
      n_fail++;
      $display("FAIL drain_count: %0d results with %0d stall cycles left, expected 8 and 0",
               n_out, stall_left);
    end
    dup = 1'b0;
    repeat (6) begin
      if (out_valid !== 1'b0) dup = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (dup) begin
      n_fail++;
      $display("FAIL drain_dup: out_valid=1 after the stream was drained, expected 0");
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] s; logic co, ov; int lat;
    bit seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_op(get_vec(i));
      @(negedge clk);
    end
    // The op offered alongside reset must never be accepted.
    reset = 1'b1;
    drive_op('{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_valid: out_valid=%b after reset, expected 0", out_valid);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL midreset_leak: a discarded op reached the output, expected none");
    end
    run_op('{16'h0F00, 16'h00F0, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0}, s, co, ov, lat);
    n_tests++;
    if (lat != 4 || {s, co, ov} !== {16'h0FF0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_new: got %h/%b/%b lat %0d, expected 0ff0/0/0 lat 4", s, co, ov, lat);
    end
  endtask

  task automatic test_random();
    logic [17:0] q [$];
    logic [17:0] exp;
    int accepted, checked;
    accepted = 0; checked = 0;
    for (int c = 0; c < 80000 && checked < 10000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (accepted < 10000 && $urandom_range(0, 3) != 0) begin
        a        = 16'($urandom);
        b        = 16'($urandom);
        carry_in = 1'($urandom);
        sub      = 1'($urandom);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: result %h with no op outstanding, expected none", sum);
        end else begin
          exp = q.pop_front();
          if ({sum, carry_out, overflow} !== exp) begin
            n_fail++;
            $display("FAIL rand[%0d]: got %h/%b/%b, expected %h/%b/%b",
                     checked, sum, carry_out, overflow, exp[17:2], exp[1], exp[0]);
          end
        end
        checked++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        q.push_back(model(a, b, carry_in, sub));
        accepted++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++;
    if (checked != 10000) begin
      n_fail++;
      $display("FAIL rand_count: %0d results checked, expected 10000", checked);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    sub       = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset();
    test_latency();
    test_carry_chain();
    test_subtract();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
